// File: rtl/lsu_ram_ctrl_if.sv
// rtl/lsu_ram_ctrl_if.sv - request, response and data-RAM port bundle for lsu_ram_ctrl
interface lsu_ram_ctrl_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;

    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;

    logic        ram_wr_en_o;
    logic [19:0] ram_wr_addr_o;
    logic [31:0] ram_wr_data_o;
    logic        ram_rd_en_o;
    logic [19:0] ram_rd_addr_o;
    logic [31:0] ram_rd_data_i;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  resp_ready_i, ram_rd_data_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        output ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o, ram_rd_en_o, ram_rd_addr_o
    );

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output resp_ready_i, ram_rd_data_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        input  ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o, ram_rd_en_o, ram_rd_addr_o
    );
endinterface

// File: rtl/lsu_ram_ctrl.sv
// rtl/lsu_ram_ctrl.sv - byte/half/word load-store controller in front of a word-wide data RAM
// Sub-word stores are read-modify-write; word-crossing accesses take a second (HI) RAM cycle.
module lsu_ram_ctrl #(
    parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
    parameter int          RAM_WORDS = 1024
) (
    input  logic          clk_i,
    input  logic          rst_i,
    lsu_ram_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

    localparam logic [31:0] RAM_WORDS_W = 32'(RAM_WORDS);

    state_t      state_q, state_d;
    logic        we_q, uns_q, cross_q, err_q;
    logic [1:0]  size_q, boff_q;
    logic [2:0]  nb_q;
    logic [19:0] wlo_q;
    logic [31:0] wdata_q, data_q, data_nxt;

    // Request decode, evaluated on the incoming request while IDLE
    logic [31:0] off, wfull, whi_full;
    logic [2:0]  nb_in, span;
    logic        cross_in, err_in;

    always_comb begin
        off      = bus.req_addr_i - RAM_BASE;
        wfull    = {2'b00, off[31:2]};
        whi_full = wfull + 32'd1;
        case (bus.req_size_i)
            2'd0:    nb_in = 3'd1;
            2'd1:    nb_in = 3'd2;
            default: nb_in = 3'd4;
        endcase
        span     = {1'b0, off[1:0]} + nb_in;
        cross_in = (span > 3'd4);
        err_in   = (bus.req_size_i == 2'd3) || (bus.req_addr_i < RAM_BASE) ||
                   (wfull >= RAM_WORDS_W) || (cross_in && (whi_full >= RAM_WORDS_W));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            cross_q <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'd0;
            boff_q  <= 2'd0;
            nb_q    <= 3'd0;
            wlo_q   <= 20'd0;
            wdata_q <= 32'd0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.req_valid_i) begin
                we_q    <= bus.req_we_i;
                uns_q   <= bus.req_unsigned_i;
                cross_q <= cross_in;
                err_q   <= err_in;
                size_q  <= bus.req_size_i;
                boff_q  <= off[1:0];
                nb_q    <= nb_in;
                wlo_q   <= off[21:2];
                wdata_q <= bus.req_wdata_i;
                data_q  <= 32'd0;
            end else if (state_q == LO || state_q == HI) begin
                data_q  <= data_nxt;
            end
        end
    end

    int          bo, nb;
    logic [31:0] wr_word, ext_data;

    always_comb begin
        state_d  = state_q;
        data_nxt = data_q;
        wr_word  = bus.ram_rd_data_i;
        bo       = int'(boff_q);
        nb       = int'(nb_q);

        bus.req_ready_o   = 1'b0;
        bus.resp_valid_o  = 1'b0;
        bus.resp_rdata_o  = 32'd0;
        bus.resp_err_o    = 1'b0;
        bus.ram_wr_en_o   = 1'b0;
        bus.ram_wr_addr_o = 20'd0;
        bus.ram_wr_data_o = 32'd0;
        bus.ram_rd_en_o   = 1'b0;
        bus.ram_rd_addr_o = 20'd0;

        case (size_q)
            2'd0:    ext_data = uns_q ? {24'd0, data_q[7:0]}  : {{24{data_q[7]}}, data_q[7:0]};
            2'd1:    ext_data = uns_q ? {16'd0, data_q[15:0]} : {{16{data_q[15]}}, data_q[15:0]};
            default: ext_data = data_q;
        endcase

        case (state_q)
            IDLE: begin
                bus.req_ready_o = 1'b1;
                if (bus.req_valid_i) state_d = err_in ? RESP : LO;
            end
            LO: begin
                // Word bytes boff.. map onto request bytes 0..
                for (int k = 0; k < 4; k++) begin
                    if (k >= bo) begin
                        data_nxt[8*(k-bo) +: 8] = bus.ram_rd_data_i[8*k +: 8];
                        if (k - bo < nb) wr_word[8*k +: 8] = wdata_q[8*(k-bo) +: 8];
                    end
                end
                bus.ram_rd_en_o   = 1'b1;
                bus.ram_rd_addr_o = wlo_q;
                bus.ram_wr_en_o   = we_q;
                bus.ram_wr_addr_o = we_q ? wlo_q : 20'd0;
                bus.ram_wr_data_o = we_q ? wr_word : 32'd0;
                state_d = cross_q ? HI : RESP;
            end
            HI: begin
                // Remaining request bytes (4-boff).. land in word bytes 0..
                for (int k = 0; k < 4; k++) begin
                    if (k < bo + nb - 4) begin
                        data_nxt[8*(4-bo+k) +: 8] = bus.ram_rd_data_i[8*k +: 8];
                        wr_word[8*k +: 8]         = wdata_q[8*(4-bo+k) +: 8];
                    end
                end
                bus.ram_rd_en_o   = 1'b1;
                bus.ram_rd_addr_o = wlo_q + 20'd1;
                bus.ram_wr_en_o   = we_q;
                bus.ram_wr_addr_o = we_q ? wlo_q + 20'd1 : 20'd0;
                bus.ram_wr_data_o = we_q ? wr_word : 32'd0;
                state_d = RESP;
            end
            RESP: begin
                bus.resp_valid_o = 1'b1;
                bus.resp_err_o   = err_q;
                bus.resp_rdata_o = (err_q || we_q) ? 32'd0 : ext_data;
                if (bus.resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A reset edge must not also commit a pending RAM write
        if (rst_i) begin
            bus.ram_wr_en_o   = 1'b0;
            bus.ram_wr_addr_o = 20'd0;
            bus.ram_wr_data_o = 32'd0;
            bus.ram_rd_en_o   = 1'b0;
            bus.ram_rd_addr_o = 20'd0;
        end
    end
endmodule

// File: tb/tb_lsu_ram_ctrl.sv
// tb/tb_lsu_ram_ctrl.sv - directed self-checking bench for lsu_ram_ctrl
module tb_lsu_ram_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_ram_ctrl_if bus ();

    lsu_ram_ctrl #(.RAM_BASE(32'h0000_0000), .RAM_WORDS(1024)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [31:0] mem [0:1023];
    logic        pl_en;
    logic [9:0]  pl_addr;
    logic [31:0] pl_data;
    logic [19:0] rd_log [0:63];
    int          rd_n = 0;
    int          wr_n = 0;
    int          vectors = 0;
    int          fails = 0;

    assign bus.ram_rd_data_i = mem[bus.ram_rd_addr_o[9:0]];

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bus.ram_wr_en_o) mem[bus.ram_wr_addr_o[9:0]] <= bus.ram_wr_data_o;
        if (bus.ram_rd_en_o) begin
            if (rd_n < 64) rd_log[rd_n] <= bus.ram_rd_addr_o;
            rd_n <= rd_n + 1;
        end
        if (bus.ram_wr_en_o) wr_n <= wr_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Issue one request and wait for its response; leaves resp pending
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, output int lat);
        bus.req_valid_i = 1'b1; bus.req_we_i = we; bus.req_size_i = size;
        bus.req_unsigned_i = uns; bus.req_addr_i = addr; bus.req_wdata_i = wdata;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        lat = 1;
        while (!bus.resp_valid_o && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
        int lat;
        issue(we, size, uns, addr, wdata, lat);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " rdata"}, bus.resp_rdata_o, exp_data);
        check({tag, " err"}, {31'd0, bus.resp_err_o}, {31'd0, exp_err});
        bus.resp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready_i = 1'b0;
        check({tag, " valid drop"}, {31'd0, bus.resp_valid_o}, 32'd0);
    endtask

    initial begin
        int lat, rd0, wr0;
        logic [31:0] held;
        rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_size_i = 2'd0;
        bus.req_unsigned_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
        bus.resp_ready_i = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst req_ready", {31'd0, bus.req_ready_o}, 32'd1);
        check("rst resp_valid", {31'd0, bus.resp_valid_o}, 32'd0);
        check("rst resp_rdata", bus.resp_rdata_o, 32'd0);
        check("rst resp_err", {31'd0, bus.resp_err_o}, 32'd0);
        check("rst ram en", {30'd0, bus.ram_rd_en_o, bus.ram_wr_en_o}, 32'd0);
        check("rst ram addr", {12'd0, bus.ram_rd_addr_o | bus.ram_wr_addr_o}, 32'd0);
        rst = 1'b0;

        preload(10'd0, 32'h8899_AABB);
        run_req("lb s a1", 1'b0, 2'd0, 1'b0, 32'h1, 32'h0, 32'hFFFF_FFAA, 1'b0, 2);
        run_req("lhu a2", 1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 32'h0000_8899, 1'b0, 2);
        run_req("lh s a2", 1'b0, 2'd1, 1'b0, 32'h2, 32'h0, 32'hFFFF_8899, 1'b0, 2);
        run_req("lbu a3", 1'b0, 2'd0, 1'b1, 32'h3, 32'h0, 32'h0000_0088, 1'b0, 2);

        preload(10'd0, 32'h4433_2211);
        preload(10'd1, 32'h8877_6655);
        rd0 = rd_n;
        run_req("lw a3 cross", 1'b0, 2'd2, 1'b0, 32'h3, 32'h0, 32'h7766_5544, 1'b0, 3);
        check("lw cross reads", rd_n - rd0, 2);
        check("lw cross rd addr0", {12'd0, rd_log[rd0]}, 32'd0);
        check("lw cross rd addr1", {12'd0, rd_log[rd0+1]}, 32'd1);

        run_req("sw a2 cross", 1'b1, 2'd2, 1'b0, 32'h2, 32'hDDCC_BBAA, 32'h0, 1'b0, 3);
        check("sw word0", mem[0], 32'hBBAA_2211);
        check("sw word1", mem[1], 32'h8877_DDCC);

        run_req("sb a5", 1'b1, 2'd0, 1'b0, 32'h5, 32'hFFFF_FF5A, 32'h0, 1'b0, 2);
        check("sb word1", mem[1], 32'h8877_5ACC);
        check("sb word0 untouched", mem[0], 32'hBBAA_2211);

        rd0 = rd_n; wr0 = wr_n;
        run_req("lw oob", 1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0, 32'h0, 1'b1, 1);
        run_req("size3", 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1);
        run_req("lh cross last", 1'b0, 2'd1, 1'b0, 32'h0000_0FFF, 32'h0, 32'h0, 1'b1, 1);
        check("err no ram rd", rd_n - rd0, 0);
        check("err no ram wr", wr_n - wr0, 0);

        issue(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, lat);
        check("hold latency", lat, 2);
        held = bus.resp_rdata_o;
        check("hold rdata", held, 32'h8877_5ACC);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("hold valid", {31'd0, bus.resp_valid_o}, 32'd1);
            check("hold stable", bus.resp_rdata_o, 32'h8877_5ACC);
            check("hold req_ready", {31'd0, bus.req_ready_o}, 32'd0);
        end
        bus.resp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready_i = 1'b0;
        check("hold release", {31'd0, bus.resp_valid_o}, 32'd0);

        bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_size_i = 2'd2;
        bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h2; bus.req_wdata_i = 32'h1234_5678;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        @(posedge clk); #1;
        check("mid HI rd addr", {12'd0, bus.ram_rd_addr_o}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst HI req_ready", {31'd0, bus.req_ready_o}, 32'd1);
        check("rst HI resp_valid", {31'd0, bus.resp_valid_o}, 32'd0);
        check("rst HI word1", mem[1], 32'h8877_5ACC);
        check("rst HI word0 kept", mem[0], 32'h5678_2211);

        run_req("lw after rst", 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 32'h8877_5ACC, 1'b0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/lsu_ram_ctrl.md
Name: lsu_ram_ctrl

Overview:
Load/store controller directly upstream of the data RAM in the rv32imac core. It accepts byte, halfword and word load/store requests from the execute stage over a valid/ready handshake. It converts each request into word-granular RAM accesses: read-modify-write for sub-word stores, and two word accesses for misaligned transfers that cross a word boundary. It returns sign- or zero-extended load data on a valid/ready response channel.

Parameters:
RAM_BASE, 32'h0000_0000, byte address of RAM word 0.
RAM_WORDS, 1024, number of 32-bit words implemented. Must be ≤ 2^20.

Ports:
clk_i  input  1  clock; all state updates on posedge.
rst_i  input  1  reset; synchronous, active-high.
req_valid_i  input  1  request valid.
req_ready_o  output  1  controller can accept a request.
req_we_i  input  1  1 = store, 0 = load.
req_size_i  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
req_unsigned_i  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
req_addr_i  input  32  byte address.
req_wdata_i  input  32  store data, LSB-aligned.
resp_valid_o  output  1  response valid.
resp_ready_i  input  1  consumer accepts the response.
resp_rdata_o  output  32  extended load data; 0 for stores and errors.
resp_err_o  output  1  access fault.
ram_wr_en_o  output  1  RAM write enable.
ram_wr_addr_o  output  20  RAM write word address.
ram_wr_data_o  output  32  RAM write data.
ram_rd_en_o  output  1  RAM read enable.
ram_rd_addr_o  output  20  RAM read word address.
ram_rd_data_i  input  32  RAM read data; combinational from ram_rd_addr_o.

Behaviour:
- States: IDLE, LO, HI, RESP. Reset (rst_i=1 at posedge) forces IDLE from any state, including mid-access.
- Reset values: req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, all ram_* outputs 0.
- Any request in flight when reset asserts is dropped. A store whose LO write already occurred is not undone.
- req_ready_o=1 only in IDLE.
- Request is accepted on a posedge with req_valid_i & req_ready_o. On acceptance, latch we, size, unsigned, addr, wdata.
- Offset computation: off = (addr - RAM_BASE); wlo = off[21:2]; boff = off[1:0]; nbytes = 1/2/4 from size; cross = (boff + nbytes > 4); whi = wlo + 1.
- Error conditions: size==3, addr < RAM_BASE, wlo ≥ RAM_WORDS, or (cross and whi ≥ RAM_WORDS).
- Error handling: IDLE → RESP directly with resp_err_o=1 and resp_rdata_o=0. No RAM access is made.
- Otherwise IDLE → LO.
- LO: ram_rd_en_o=1, ram_rd_addr_o=wlo.
  - Load: capture bytes boff..min(3, boff+nbytes-1) of ram_rd_data_i into data bytes 0.. (little-endian).
  - Store: ram_wr_en_o=1, ram_wr_addr_o=wlo, ram_wr_data_o = ram_rd_data_i with bytes boff.. replaced by low wdata bytes.
  - Next state: HI if cross, else RESP.
- HI: same as LO at word whi, covering the remaining bytes.
  - Load: captured bytes continue at data byte (4 - boff).
  - Store: writes the following wdata bytes into word bytes 0...
  - Next state: RESP.
- ram_* outputs are 0 in IDLE and RESP.
- RESP: resp_valid_o=1.
  - resp_rdata_o = captured data extended from 8/16 bits per size and unsigned. Word loads pass through unchanged. Stores return 0.
  - Hold all response outputs stable until resp_ready_i. On the handshake edge go to IDLE; resp_valid_o drops next cycle.
- Latency from accept edge to resp_valid_o: aligned or non-crossing = 2 cycles; crossing = 3 cycles; error = 1 cycle.
- Throughput: at most one request per 3 cycles, because IDLE is revisited between requests.
- RAM write lands at the posedge ending LO. The HI cycle reads a different word, so there is no read-after-write hazard within a request.

Test Plan:
- RAM word 0 = 32'h8899_AABB; load byte addr 0x1 signed → resp_rdata 32'hFFFF_FFAA, err 0, resp_valid 2 cycles after accept.
- Same word; load half addr 0x2 unsigned → 32'h0000_8899. Load half addr 0x2 signed → 32'hFFFF_8899.
- Words 0,1 = 32'h4433_2211, 32'h8877_6655; load word addr 0x3 → 32'h7766_5544. RAM reads at addr 0 then addr 1; response 3 cycles after accept.
- Store word 32'hDDCC_BBAA at addr 0x2 over the words above → word0 = 32'hBBAA_2211, word1 = 32'h8877_DDCC.
- Store byte 0x5A at addr 0x5 → word1 byte1 only changes. Then RAM_BASE+4*RAM_WORDS load → err 1, rdata 0, no ram_rd_en/ram_wr_en pulses. Also size=3 → err 1.
- Hold resp_ready_i=0 for 5 cycles → response held stable, req_ready_o=0. Also assert rst_i during HI of a crossing store → next cycle IDLE, req_ready_o=1, resp_valid_o=0, word1 unchanged.
